// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller and its helpers.
//   - XLEN: data/address width of the memory bus
//   - size_e: access size encodings (byte/half/word/double)
//   - state_e: controller FSM states
//   - is_misaligned(): natural-alignment check for an access
package lsu_mem_ctrl_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // An access is misaligned when any offset bit below its natural size is set.
  function automatic logic is_misaligned(logic [2:0] off, size_e size);
    logic mis;
    case (size)
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle between the execute stage, the load/store controller and the
// data memory.
//   req_*  : request handshake from execute (valid/ready)
//   resp_* : response handshake back to execute (valid/ready)
//   mem_*  : strobes/data to the memory model, mem_rdata returned combinationally
// Modports: slave = controller side, master = execute stage + memory side.
interface lsu_mem_ctrl_if;
  import lsu_mem_ctrl_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  logic [XLEN-1:0] mem_addr;
  logic            mem_ce;
  logic            mem_we;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_ce, mem_we, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load aligner: picks the addressed bytes out of a 64-bit
// memory word and sign- or zero-extends them to 64 bits.
//   raw : 64-bit word as read from memory (8-byte aligned)
//   off : byte offset within the word
//   size: access size (SZ_B..SZ_D)
//   uns : 1 = zero-extend, 0 = sign-extend (ignored for doubles)
//   ext : aligned, extended result
module lsu_load_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      off,
  input  size_e           size,
  input  logic            uns,
  output logic [XLEN-1:0] ext
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = raw >> {off, 3'b000};
    case (size)
      SZ_B:    ext = uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SZ_H:    ext = uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SZ_W:    ext = uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the data memory model.
// Accepts one request at a time, drives an aligned memory access for
// ACCESS_CYCLES cycles (write strobe only in the last one), aligns load data
// and returns a response; misaligned requests skip memory and answer with err.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : lsu_mem_ctrl_if.slave (request, response and memory signals)
// ACCESS_CYCLES: cycles mem_ce is held per access, 1..15.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int ACCESS_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_ctrl_if.slave  bus
);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept;
  logic            last;
  logic            req_mis;

  logic            we_q;
  logic            err_q;
  size_e           size_q;
  logic            uns_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] load_ext;
  logic [2:0]      off_q;
  logic [7:0]      lanes;

  assign off_q   = addr_q[2:0];
  assign last    = (cnt_q == 4'(ACCESS_CYCLES - 1));
  assign req_mis = is_misaligned(bus.req_addr[2:0], size_e'(bus.req_size));

  lsu_load_align u_align (
    .raw  (bus.mem_rdata),
    .off  (off_q),
    .size (size_q),
    .uns  (uns_q),
    .ext  (load_ext)
  );

  // State / control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= bus.req_we;
        err_q <= req_mis;
      end
    end
  end

  // Request data and load result; outputs are gated by state, so no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      size_q  <= size_e'(bus.req_size);
      uns_q   <= bus.req_unsigned;
      rdata_q <= '0;
    end else if (state_q == ACCESS && last && !we_q) begin
      rdata_q <= load_ext;
    end
  end

  // Next state, handshakes and memory strobes
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    accept         = 1'b0;
    lanes          = 8'h00;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_ce     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_wdata  = '0;
    bus.mem_wmask  = 8'h00;

    case (size_q)
      SZ_B:    lanes = 8'h01;
      SZ_H:    lanes = 8'h03;
      SZ_W:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'd0;
          state_d = req_mis ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_ce    = 1'b1;
        // One write per store: strobe only in the cycle the access completes.
        bus.mem_we    = we_q && last;
        bus.mem_addr  = {addr_q[XLEN-1:3], 3'b000};
        bus.mem_wdata = wdata_q << {off_q, 3'b000};
        bus.mem_wmask = lanes << off_q;
        if (last) begin
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
